// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command bridge.
// Frame opcodes, reply codes and the bridge FSM state encoding.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        GET_DATA,
        BUS,
        SEND,
        WAIT_TX
    } state_t;

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] RSP_ACK  = 8'h06;
    localparam logic [7:0] RSP_NAK  = 8'h15;

    function automatic logic is_opcode(input logic [7:0] b);
        return (b == OP_WRITE) || (b == OP_READ);
    endfunction

endpackage

// File: rtl/uart_cmd_timeout.sv
// Inter-byte timeout counter for the UART command bridge.
// Counts enabled cycles; clear restarts it; expire pulses on the last one.
module uart_cmd_timeout #(
    parameter int CYC = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expire
);

    localparam int CW = $clog2(CYC + 1);
    localparam logic [CW-1:0] LAST = CW'(CYC - 1);

    logic [CW-1:0] cnt;

    assign expire = en && !clear && (cnt == LAST);

    // Cycle counter, restarted by clear and after each expiry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear || expire) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_cmd_bridge.sv
// UART command bridge: parses write/read frames into bus accesses
// and returns one reply byte per accepted frame.
module uart_cmd_bridge
    import uart_cmd_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_done,
    input  logic              rx_parity_err,
    output logic [7:0]        tx_data,
    output logic              tx_en,
    input  logic              tx_busy,
    input  logic              tx_done,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack,
    output logic              busy,
    output logic              overrun
);

    logic [1:0]        rst_sync;
    logic              rst_i;
    state_t            state, state_d;
    logic [7:0]        op, op_d;
    logic [7:0]        reply, reply_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d;
    logic              req_d, we_d;
    logic [7:0]        txd_d;
    logic              txen_d;
    logic              to_en, to_clr, to_exp;

    // Asynchronous assertion, clk-synchronous release of internal reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_i = rst_sync[1];

    assign to_en  = (state == GET_ADDR) || (state == GET_DATA);
    assign to_clr = rx_done || !to_en;

    uart_cmd_timeout #(
        .CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk   (clk),
        .rst   (rst_i),
        .clear (to_clr),
        .en    (to_en),
        .expire(to_exp)
    );

    assign busy    = (state != IDLE);
    assign overrun = rx_done &&
                     ((state == BUS) || (state == SEND) || (state == WAIT_TX));

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state;
        op_d    = op;
        reply_d = reply;
        addr_d  = bus_addr;
        wdata_d = bus_wdata;
        req_d   = bus_req;
        we_d    = bus_we;
        txd_d   = tx_data;
        txen_d  = 1'b0;
        unique case (state)
            IDLE: begin
                if (rx_done) begin
                    if (!rx_parity_err && is_opcode(rx_data)) begin
                        op_d    = rx_data;
                        state_d = GET_ADDR;
                    end else begin
                        reply_d = RSP_NAK;
                        state_d = SEND;
                    end
                end
            end
            GET_ADDR: begin
                if (rx_done) begin
                    if (rx_parity_err) begin
                        op_d    = '0;
                        reply_d = RSP_NAK;
                        state_d = SEND;
                    end else begin
                        addr_d = rx_data[ADDR_W-1:0];
                        if (op == OP_WRITE) begin
                            state_d = GET_DATA;
                        end else begin
                            req_d   = 1'b1;
                            we_d    = 1'b0;
                            state_d = BUS;
                        end
                    end
                end else if (to_exp) begin
                    op_d    = '0;
                    state_d = IDLE;
                end
            end
            GET_DATA: begin
                if (rx_done) begin
                    if (rx_parity_err) begin
                        op_d    = '0;
                        reply_d = RSP_NAK;
                        state_d = SEND;
                    end else begin
                        wdata_d = rx_data[DATA_W-1:0];
                        req_d   = 1'b1;
                        we_d    = (op == OP_WRITE);
                        state_d = BUS;
                    end
                end else if (to_exp) begin
                    op_d    = '0;
                    state_d = IDLE;
                end
            end
            BUS: begin
                if (bus_ack) begin
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    reply_d = bus_we ? RSP_ACK : bus_rdata;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (!tx_busy) begin
                    txd_d   = reply;
                    txen_d  = 1'b1;
                    state_d = WAIT_TX;
                end
            end
            WAIT_TX: begin
                if (tx_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; all cleared while reset is held.
    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            state     <= IDLE;
            op        <= '0;
            reply     <= '0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            tx_data   <= '0;
            tx_en     <= 1'b0;
        end else begin
            state     <= state_d;
            op        <= op_d;
            reply     <= reply_d;
            bus_addr  <= addr_d;
            bus_wdata <= wdata_d;
            bus_req   <= req_d;
            bus_we    <= we_d;
            tx_data   <= txd_d;
            tx_en     <= txen_d;
        end
    end

endmodule

// File: doc/uart_cmd_bridge.md
UART_CMD_BRIDGE -- requirements
Module: uart_cmd_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning bus address width, a multiple of 8 with a maximum of 8 in this revision.
REQ-002 SHALL have parameter DATA_W, default 8, meaning bus data width, fixed to the UART byte width.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 50000, meaning the inter-byte timeout within a frame, in clk cycles.
REQ-004 SHALL have: clk  in  1  single system clock; all logic on posedge.
REQ-005 SHALL have: rst  in  1  asynchronous, active-low reset.
REQ-006 SHALL have: rx_data  in  8  received byte from the UART receiver.
REQ-007 SHALL have: rx_done  in  1  one-cycle pulse; rx_data is valid.
REQ-008 SHALL have: rx_parity_err  in  1  parity error for the byte flagged by rx_done.
REQ-009 SHALL have: tx_data  out  8  response byte to the UART transmitter.
REQ-010 SHALL have: tx_en  out  1  one-cycle transmit request.
REQ-011 SHALL have: tx_busy  in  1  transmitter busy.
REQ-012 SHALL have: tx_done  in  1  one-cycle pulse; byte fully sent.
REQ-013 SHALL have: bus_req, bus_we  out  1 each  bus request and write strobe.
REQ-014 SHALL have: bus_addr  out  ADDR_W  and  bus_wdata  out  DATA_W.
REQ-015 SHALL have: bus_rdata  in  DATA_W  and  bus_ack  in  1  one-cycle completion pulse.
REQ-016 SHALL have: busy  out  1  high whenever the FSM is not in IDLE.
REQ-017 SHALL have: overrun  out  1  one-cycle pulse when a byte is dropped.

Function
REQ-018 SHALL support these frames:
- Write: 0x57, addr, data. Performs a bus write, then replies 0x06 (ACK).
- Read: 0x52, addr. Performs a bus read, then replies with the rdata byte.
REQ-019 SHALL use FSM states IDLE, GET_ADDR, GET_DATA, BUS, SEND, WAIT_TX.
REQ-020 SHALL handle opcodes in IDLE as follows:
- rx_done with 0x57 or 0x52 latches the opcode and moves to GET_ADDR.
- Any other byte sets the reply to 0x15 (NAK) and moves to SEND.
REQ-021 SHALL, in GET_ADDR on rx_done, latch bus_addr, then go to GET_DATA for a write or to BUS for a read.
REQ-022 SHALL, in GET_DATA on rx_done, latch bus_wdata and go to BUS.
REQ-023 SHALL assert bus_req in BUS with bus_we = (opcode == 0x57), holding bus_req, bus_we, bus_addr and bus_wdata stable until bus_ack.
REQ-024 SHALL, on bus_ack, deassert bus_req on the next edge, latch bus_rdata for a read (0x06 for a write) as the reply, and go to SEND.
REQ-025 SHALL accept bus_ack coincident with the first cycle of bus_req.
REQ-026 SHALL ignore bus_ack outside BUS.
REQ-027 SHALL, in SEND with tx_busy low, drive tx_data with the reply, pulse tx_en for exactly one cycle, and go to WAIT_TX; with tx_busy high it SHALL stay in SEND.
REQ-028 SHALL, in WAIT_TX, return to IDLE on tx_done; tx_data SHALL stay stable until then.
REQ-029 SHALL, on rx_done with rx_parity_err high in IDLE, GET_ADDR or GET_DATA, discard the byte and any partial frame, set the reply to 0x15, and go to SEND.
REQ-030 SHALL, in GET_ADDR or GET_DATA, abort to IDLE with no reply and no bus access when TIMEOUT_CYC cycles pass without rx_done; the counter SHALL reset on every accepted byte.
REQ-031 SHALL, on rx_done in BUS, SEND or WAIT_TX, drop the byte, pulse overrun the same cycle, and leave the state unchanged.
REQ-032 SHALL have latency from the last frame byte's rx_done to bus_req of 1 cycle, and from bus_ack to tx_en of 2 cycles (minimum, tx_busy low).
REQ-033 SHALL issue at most one bus access and exactly one reply per accepted frame; a timed-out frame gets zero replies.

Reset
REQ-034 SHALL, while rst is low, immediately force state to IDLE and all outputs to 0: tx_data, tx_en, bus_req, bus_we, bus_addr, bus_wdata, busy, overrun.
REQ-035 SHALL clear the timeout counter, opcode register and reply register on reset.
REQ-036 SHALL, on reset assertion mid-frame or mid-bus-access, drop bus_req asynchronously with no reply; after release it SHALL wait for a fresh opcode.
REQ-037 SHALL release reset synchronously to clk, using a two-flop release synchronizer inside the block.

Structure
REQ-038 SHALL place the FSM state enum and the constants OP_WRITE=0x57, OP_READ=0x52, RSP_ACK=0x06 and RSP_NAK=0x15 in a shared package, uart_cmd_pkg.
REQ-039 SHALL, as its one natural sub-module, use uart_cmd_timeout (load/clear, count, expire pulse).
REQ-040 SHALL connect directly to the existing UART wrapper's RX_dataOut/RX_done/RX_parityError and TX_dataIn/TX_en/TX_busy/TX_done ports with no glue logic.

Verification
REQ-041 SHALL cover write: rx 0x57, 0x3C, 0xA5 -> one bus_req with we=1, addr=0x3C, wdata=0xA5; after ack, one tx_en with tx_data=0x06.
REQ-042 SHALL cover read with ack delayed 5 cycles: rx 0x52, 0x10; bus_rdata=0x7E -> bus_req held 5 cycles, we=0; tx_data=0x7E.
REQ-043 SHALL cover a bad opcode and a parity error: rx 0x41 -> tx_data=0x15, no bus_req; rx 0x57 then addr with rx_parity_err=1 -> tx_data=0x15, no bus_req.
REQ-044 SHALL cover timeout with TIMEOUT_CYC=100: rx 0x57, 0x20, then 150 idle cycles -> busy low after cycle 100, no tx_en, no bus_req.
REQ-045 SHALL cover overrun: rx_done pulsed while in WAIT_TX -> overrun pulse; the original reply completes; the next frame is parsed correctly.
REQ-046 SHALL cover mid-access reset: rst low while bus_req=1 -> bus_req=0 immediately; after release, 0x52, 0x01 yields a normal read.
